// File: rtl/sum_stationary_pkg.sv
// Shared types and width helpers for the sum_stationary job sequencer.
// The sequencer and its result buffer both import this package.
package sum_stationary_pkg;

    typedef enum logic [1:0] {
        SEQ_CLEAR = 2'd0,
        SEQ_FEED  = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_HOLD  = 2'd3
    } seq_state_e;

    localparam int JOBS_CNT_W = 16;

    // Width of one C element: full product plus log2(N) bits of accumulation growth.
    function automatic int C_WIDTH(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/sum_stationary_sequencer_result_row_buffer.sv
// Result buffer: captures a full C matrix from the array in one cycle and
// drains it one row per accepted transfer on a valid/ready port.
module result_row_buffer
    import sum_stationary_pkg::*;
#(
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = 18,
    parameter int IDX_W        = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            capture,
    input  logic [N*N*C_DATA_WIDTH-1:0]     c_data,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [N*C_DATA_WIDTH-1:0]       res_row,
    output logic [IDX_W-1:0]                res_row_idx,
    output logic                            res_last,
    output logic                            last_pop,
    output logic                            can_capture,
    output logic                            full
);

    localparam int ROW_W = N * C_DATA_WIDTH;

    logic [ROW_W-1:0] rows [N];
    logic [IDX_W-1:0] row_idx;
    logic             pop;

    assign pop         = full & res_ready;
    assign res_last    = (row_idx == IDX_W'(N - 1));
    assign last_pop    = pop & res_last;
    // A capture may land on the same edge as the final pop of the previous job.
    assign can_capture = !full | last_pop;

    assign res_valid   = full;
    assign res_row_idx = row_idx;
    assign res_row     = full ? rows[row_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 1'b0;
            row_idx <= '0;
        end else if (capture) begin
            full    <= 1'b1;
            row_idx <= '0;
        end else if (pop) begin
            if (res_last) begin
                full    <= 1'b0;
                row_idx <= '0;
            end else begin
                row_idx <= row_idx + IDX_W'(1);
            end
        end
    end

    // Data registers carry no reset; res_row is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int r = 0; r < N; r++) begin
                rows[r] <= c_data[r*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: rtl/sum_stationary_sequencer.sv
// Job sequencer around one sum_stationary NxN array: feeds N operand beats,
// clears the array between jobs and hands the finished C matrix to a row-drain buffer.
module sum_stationary_sequencer
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = C_WIDTH(DATA_WIDTH, N)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N*DATA_WIDTH-1:0]         in_a_col,
    input  logic [N*DATA_WIDTH-1:0]         in_b_row,
    input  logic                            in_last,
    output logic                            arr_reset,
    output logic                            arr_input_valid,
    output logic [N*DATA_WIDTH-1:0]         arr_a_data,
    output logic [N*DATA_WIDTH-1:0]         arr_b_data,
    input  logic                            arr_output_valid,
    input  logic [N*N*C_DATA_WIDTH-1:0]     arr_c_data,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [N*C_DATA_WIDTH-1:0]       res_row,
    output logic [$clog2(N)-1:0]            res_row_idx,
    output logic                            res_last,
    output logic                            busy,
    output logic                            protocol_err,
    output logic [JOBS_CNT_W-1:0]           jobs_done
);

    localparam int IDX_W  = $clog2(N);
    localparam int BEAT_W = $clog2(N + 1);

    localparam logic [1:0] CLEAR = SEQ_CLEAR;
    localparam logic [1:0] FEED  = SEQ_FEED;
    localparam logic [1:0] RUN   = SEQ_RUN;
    localparam logic [1:0] HOLD  = SEQ_HOLD;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

    logic [1:0]        state;
    logic [BEAT_W-1:0] beat_cnt;
    logic              accept;
    logic              beat_last;
    logic              in_run;
    logic              capture;
    logic              can_capture;
    logic              last_pop;
    logic              rbuf_full;

    // Both ports use valid/ready: a transfer happens on any edge where valid and
    // ready are high together; valid and its payload hold until that edge.
    assign in_ready        = (state == FEED);
    assign accept          = in_valid & in_ready;
    assign arr_reset       = reset | (state == CLEAR);
    assign arr_input_valid = accept;
    assign arr_a_data      = in_ready ? in_a_col : '0;
    assign arr_b_data      = in_ready ? in_b_row : '0;

    assign beat_last = (beat_cnt == LAST_BEAT);
    assign in_run    = (state == RUN) | (state == HOLD);
    assign capture   = in_run & arr_output_valid & can_capture;
    assign busy      = (state != FEED) | (beat_cnt != '0) | rbuf_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            beat_cnt <= '0;
        end else begin
            case (state)
                CLEAR: state <= FEED;
                FEED: begin
                    if (accept) begin
                        if (beat_last) begin
                            beat_cnt <= '0;
                            state    <= RUN;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                // The array keeps presenting its result until cleared, so HOLD just waits.
                RUN: begin
                    if (capture) begin
                        state <= CLEAR;
                    end else if (arr_output_valid) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (capture) begin
                        state <= CLEAR;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_err <= 1'b0;
            jobs_done    <= '0;
        end else begin
            if (accept && (in_last != beat_last)) begin
                protocol_err <= 1'b1;
            end
            if (last_pop) begin
                jobs_done <= jobs_done + JOBS_CNT_W'(1);
            end
        end
    end

    result_row_buffer #(
        .N            (N),
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .IDX_W        (IDX_W)
    ) u_rbuf (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .c_data       (arr_c_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_row      (res_row),
        .res_row_idx  (res_row_idx),
        .res_last     (res_last),
        .last_pop     (last_pop),
        .can_capture  (can_capture),
        .full         (rbuf_full)
    );

endmodule

// File: tb/tb_sum_stationary_sequencer.sv
// Bench for sum_stationary_sequencer with a behavioural array model standing in
// for the systolic array (accumulates A*B per beat, completes 2N-2 cycles later).
module tb_sum_stationary_sequencer;
    import sum_stationary_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = C_WIDTH(DW, N);

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
    typedef logic [N-1:0][N-1:0][CW-1:0] cmat_t;

    typedef struct packed {
        mat_t       a;
        mat_t       b;
        logic [7:0] last_beat;
        logic [7:0] stall_after;
        logic [7:0] stall_len;
        cmat_t      exp_c;
        logic [7:0] exp_lat;
        logic       exp_err;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DW-1:0]       in_a_col;
    logic [N*DW-1:0]       in_b_row;
    logic                  in_last;
    logic                  arr_reset;
    logic                  arr_input_valid;
    logic [N*DW-1:0]       arr_a_data;
    logic [N*DW-1:0]       arr_b_data;
    logic                  arr_output_valid;
    logic [N*N*CW-1:0]     arr_c_data;
    logic                  res_valid;
    logic                  res_ready;
    logic [N*CW-1:0]       res_row;
    logic [$clog2(N)-1:0]  res_row_idx;
    logic                  res_last;
    logic                  busy;
    logic                  protocol_err;
    logic [JOBS_CNT_W-1:0] jobs_done;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_jobs = 0;

    vec_t  vecs [4];
    mat_t  basic_a, basic_b, two_a, ones_b, max_m;
    cmat_t basic_c, twos_c, max_c;

    sum_stationary_sequencer #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a_col         (in_a_col),
        .in_b_row         (in_b_row),
        .in_last          (in_last),
        .arr_reset        (arr_reset),
        .arr_input_valid  (arr_input_valid),
        .arr_a_data       (arr_a_data),
        .arr_b_data       (arr_b_data),
        .arr_output_valid (arr_output_valid),
        .arr_c_data       (arr_c_data),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_row          (res_row),
        .res_row_idx      (res_row_idx),
        .res_last         (res_last),
        .busy             (busy),
        .protocol_err     (protocol_err),
        .jobs_done        (jobs_done)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Behavioural array model
    logic [CW-1:0] acc [N][N];
    int            m_beats;
    int            m_run;
    logic          m_ov;

    always @(posedge clk) begin
        if (arr_reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= '0;
            m_beats <= 0;
            m_run   <= 0;
            m_ov    <= 1'b0;
        end else if (arr_input_valid) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= acc[i][j] + CW'(arr_a_data[i*DW +: DW]) * CW'(arr_b_data[j*DW +: DW]);
            m_beats <= m_beats + 1;
        end else if (m_beats == N && !m_ov) begin
            if (m_run == 2*N - 3) m_ov <= 1'b1;
            else                  m_run <= m_run + 1;
        end
    end

    assign arr_output_valid = m_ov;
    always_comb begin
        arr_c_data = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_c_data[(i*N + j)*CW +: CW] = acc[i][j];
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: called at a negedge, returns at the negedge after the last beat is accepted.
    task automatic feed_job(input mat_t a, input mat_t b, input int last_beat,
                            input int stall_after, input int stall_len, output int t0);
        int w;
        t0 = 0;
        for (int k = 0; k < N; k++) begin
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) check($sformatf("in_ready timeout beat%0d", k), 128'(in_ready), 128'(1));
            for (int i = 0; i < N; i++) begin
                in_a_col[i*DW +: DW] = a[i][k];
                in_b_row[i*DW +: DW] = b[k][i];
            end
            in_last  = (k == last_beat);
            in_valid = 1'b1;
            if (k == 0) t0 = cyc + 1;
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (k == stall_after) repeat (stall_len) @(negedge clk);
        end
    endtask

    task automatic wait_res(input int t0, input int exp_lat, input string tag);
        int w;
        w = 0;
        while (!res_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({tag, " res_valid"}, 128'(res_valid), 128'(1));
        check({tag, " latency"}, 128'(cyc - t0 + 1), 128'(exp_lat));
    endtask

    task automatic drain_check(input cmat_t exp, input string tag);
        logic [N*CW-1:0] er;
        int w;
        res_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            w = 0;
            while (!res_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
            for (int j = 0; j < N; j++) er[j*CW +: CW] = exp[r][j];
            check($sformatf("%s row%0d idx", tag, r), 128'(res_row_idx), 128'(r));
            check($sformatf("%s row%0d last", tag, r), 128'(res_last), 128'(r == N - 1));
            check($sformatf("%s row%0d data", tag, r), 128'(res_row), 128'(er));
            @(negedge clk);
        end
        res_ready = 1'b0;
        exp_jobs++;
        check({tag, " jobs_done"}, 128'(jobs_done), 128'(exp_jobs));
    endtask

    initial begin
        int t0;
        logic [N*CW-1:0] er;
        reset = 1'b1; in_valid = 1'b0; in_a_col = '0; in_b_row = '0;
        in_last = 1'b0; res_ready = 1'b0;

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                basic_a[i][j] = (i == j) ? DW'(1) : DW'(0);
                basic_b[i][j] = DW'(4*i + j + 1);
                basic_c[i][j] = CW'(4*i + j + 1);
                two_a[i][j]   = (i == j) ? DW'(2) : DW'(0);
                ones_b[i][j]  = DW'(1);
                twos_c[i][j]  = CW'(2);
                max_m[i][j]   = DW'(255);
                max_c[i][j]   = CW'(260100);
            end
        vecs[0] = '{a: basic_a, b: basic_b, last_beat: 8'd3, stall_after: 8'd255, stall_len: 8'd0,
                    exp_c: basic_c, exp_lat: 8'd11, exp_err: 1'b0};
        vecs[1] = '{a: basic_a, b: basic_b, last_beat: 8'd3, stall_after: 8'd1, stall_len: 8'd3,
                    exp_c: basic_c, exp_lat: 8'd14, exp_err: 1'b0};
        vecs[2] = '{a: max_m, b: max_m, last_beat: 8'd3, stall_after: 8'd255, stall_len: 8'd0,
                    exp_c: max_c, exp_lat: 8'd11, exp_err: 1'b0};
        vecs[3] = '{a: basic_a, b: basic_b, last_beat: 8'd2, stall_after: 8'd255, stall_len: 8'd0,
                    exp_c: basic_c, exp_lat: 8'd11, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        check("rst arr_reset", 128'(arr_reset), 128'(1));
        check("rst in_ready", 128'(in_ready), 128'(0));
        check("rst res_valid", 128'(res_valid), 128'(0));
        check("rst res_row", 128'(res_row), 128'(0));
        check("rst arr_input_valid", 128'(arr_input_valid), 128'(0));
        check("rst protocol_err", 128'(protocol_err), 128'(0));
        check("rst jobs_done", 128'(jobs_done), 128'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle in_ready", 128'(in_ready), 128'(1));
        check("idle busy", 128'(busy), 128'(0));
        check("idle arr_reset", 128'(arr_reset), 128'(0));

        // Table-driven jobs
        for (int v = 0; v < 4; v++) begin
            feed_job(vecs[v].a, vecs[v].b, int'(vecs[v].last_beat), int'(vecs[v].stall_after),
                     int'(vecs[v].stall_len), t0);
            check($sformatf("v%0d busy run", v), 128'(busy), 128'(1));
            check($sformatf("v%0d in_ready run", v), 128'(in_ready), 128'(0));
            wait_res(t0, int'(vecs[v].exp_lat), $sformatf("v%0d", v));
            drain_check(vecs[v].exp_c, $sformatf("v%0d", v));
            check($sformatf("v%0d protocol_err", v), 128'(protocol_err), 128'(vecs[v].exp_err));
        end

        // Overlap with backpressure: job 2 waits in HOLD behind job 1
        feed_job(basic_a, basic_b, 3, 255, 0, t0);
        wait_res(t0, 11, "ovl job1");
        feed_job(two_a, ones_b, 3, 255, 0, t0);
        begin
            int w;
            w = 0;
            while (!arr_output_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        repeat (2) @(negedge clk);
        for (int j = 0; j < N; j++) er[j*CW +: CW] = basic_c[0][j];
        check("ovl hold in_ready", 128'(in_ready), 128'(0));
        check("ovl hold arr_ov", 128'(arr_output_valid), 128'(1));
        check("ovl hold busy", 128'(busy), 128'(1));
        check("ovl hold idx", 128'(res_row_idx), 128'(0));
        check("ovl hold row stable", 128'(res_row), 128'(er));
        drain_check(basic_c, "ovl job1");
        check("ovl same-cycle capture valid", 128'(res_valid), 128'(1));
        check("ovl same-cycle capture idx", 128'(res_row_idx), 128'(0));
        drain_check(twos_c, "ovl job2");
        check("ovl sticky protocol_err", 128'(protocol_err), 128'(1));

        // Reset mid-RUN with a full result buffer
        feed_job(basic_a, basic_b, 3, 255, 0, t0);
        wait_res(t0, 11, "rst pre");
        feed_job(max_m, max_m, 3, 255, 0, t0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst arr_reset", 128'(arr_reset), 128'(1));
        reset = 1'b0;
        @(negedge clk);
        check("midrst res_valid", 128'(res_valid), 128'(0));
        check("midrst busy", 128'(busy), 128'(0));
        check("midrst in_ready", 128'(in_ready), 128'(1));
        check("midrst protocol_err", 128'(protocol_err), 128'(0));
        check("midrst jobs_done", 128'(jobs_done), 128'(0));
        exp_jobs = 0;
        feed_job(basic_a, basic_b, 3, 255, 0, t0);
        wait_res(t0, 11, "post rst");
        drain_check(basic_c, "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
